hazard_ctrl: RTL and testbench

- Pipeline control unit that produces the hold/flush/freeze controls consumed by the PC, if_id, id_ex and ex_mem registers.
- It is the control end of the hold_flag interface: it decides when id_ex loads a NOP bubble, and when if_id is flushed or held.
- It detects load-use hazards, EX-stage jump/branch redirects, and data-memory wait states. A wait-state FSM includes timeout error reporting.
- It also maintains stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: produces hold, flush and freeze controls for the PC, if_id, id_ex and
// ex_mem registers. It also runs a memory wait-state timeout FSM and keeps stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_mem_re_i,
  input  logic             ex_jump_en_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             mem_busy_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             hold_flag_o,
  output logic             freeze_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic freeze;
  logic stall_act;

  assign load_use = ex_mem_re_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
  assign freeze   = mem_busy_i || (state_q == StErr);

  // Priority: rst > freeze > jump > load-use.
  always_comb begin
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    hold_flag_o   = 1'b0;
    freeze_o      = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    stall_act     = 1'b0;
    if (!rst) begin
      if (freeze) begin
        freeze_o = 1'b1;
      end else if (ex_jump_en_i) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = ex_jump_addr_i;
        if_id_flush_o = 1'b1;
        hold_flag_o   = 1'b1;
      end else if (load_use) begin
        pc_hold_o    = 1'b1;
        if_id_hold_o = 1'b1;
        hold_flag_o  = 1'b1;
        stall_act    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_err_d   = bus_err_q;
    stall_cnt_d = stall_cnt_q + (stall_act ? CNT_W'(1) : CNT_W'(0));
    flush_cnt_d = flush_cnt_q + (jump_en_o ? CNT_W'(1) : CNT_W'(0));
    unique case (state_q)
      StRun: begin
        if (mem_busy_i) begin
          state_d    = StWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StWait: begin
        if (!mem_busy_i) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1)) begin
          state_d   = StErr;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr: begin
        bus_err_d = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus_err_o   = bus_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a 32-bit-counter instance and a 4-bit-counter instance share
// directed stimulus; expected outputs are queued per cycle and checked by a negedge monitor.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, re, jen, busy;
  logic [31:0] ja;

  logic        pch_a, ifh_a, fl_a, hf_a, fz_a, je_a, berr_a;
  logic [31:0] ja_a, stall_a, flush_a;
  logic        pch_b, ifh_b, fl_b, hf_b, fz_b, je_b, berr_b;
  logic [31:0] ja_b;
  logic [3:0]  stall_b, flush_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1),
    .id_rs2_used_i(u2), .ex_rd_addr_i(rd), .ex_mem_re_i(re), .ex_jump_en_i(jen),
    .ex_jump_addr_i(ja), .mem_busy_i(busy), .pc_hold_o(pch_a), .if_id_hold_o(ifh_a),
    .if_id_flush_o(fl_a), .hold_flag_o(hf_a), .freeze_o(fz_a), .jump_en_o(je_a),
    .jump_addr_o(ja_a), .bus_err_o(berr_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
  );

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1),
    .id_rs2_used_i(u2), .ex_rd_addr_i(rd), .ex_mem_re_i(re), .ex_jump_en_i(jen),
    .ex_jump_addr_i(ja), .mem_busy_i(busy), .pc_hold_o(pch_b), .if_id_hold_o(ifh_b),
    .if_id_flush_o(fl_b), .hold_flag_o(hf_b), .freeze_o(fz_b), .jump_en_o(je_b),
    .jump_addr_o(ja_b), .bus_err_o(berr_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
  );

  // ctl bit order: {pc_hold, if_id_hold, if_id_flush, hold_flag, freeze, jump_en}
  localparam logic [5:0] CNone = 6'b000000;
  localparam logic [5:0] CLu   = 6'b110100;
  localparam logic [5:0] CJmp  = 6'b001101;
  localparam logic [5:0] CFz   = 6'b000010;

  typedef struct {
    string       name;
    logic [5:0]  ctl;
    logic [31:0] ja;
    logic        berr;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  task automatic cyc(input string nm, input logic r, input logic b, input logic lre,
                     input logic ljen, input logic [4:0] lrd, input logic [4:0] lrs1,
                     input logic [4:0] lrs2, input logic lu1, input logic lu2,
                     input logic [31:0] lja, input logic [5:0] ectl, input logic [31:0] eja,
                     input logic eberr);
    exp_t e;
    rst = r; busy = b; re = lre; jen = ljen; rd = lrd; rs1 = lrs1; rs2 = lrs2;
    u1 = lu1; u2 = lu2; ja = lja;
    e.name = nm; e.ctl = ectl; e.ja = eja; e.berr = eberr;
    e.stall = exp_stall; e.flush = exp_flush;
    exp_q.push_back(e);
    if (r) begin
      exp_stall = 32'd0;
      exp_flush = 32'd0;
    end else begin
      if (ectl[0]) exp_flush = exp_flush + 32'd1;
      if (ectl[5]) exp_stall = exp_stall + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic eberr);
    cyc(nm, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, CNone, 32'd0, eberr);
  endtask

  task automatic busy_n(input string nm, input int n);
    for (int i = 0; i < n; i++)
      cyc(nm, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, CFz, 32'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({pch_a, ifh_a, fl_a, hf_a, fz_a, je_a} !== e.ctl || ja_a !== e.ja ||
          berr_a !== e.berr || stall_a !== e.stall || flush_a !== e.flush) begin
        errors++;
        $display("FAIL %s (cnt32): got ctl=%b ja=%h berr=%b stall=%0d flush=%0d, need ctl=%b ja=%h berr=%b stall=%0d flush=%0d",
                 e.name, {pch_a, ifh_a, fl_a, hf_a, fz_a, je_a}, ja_a, berr_a, stall_a, flush_a,
                 e.ctl, e.ja, e.berr, e.stall, e.flush);
      end
      checks++;
      if ({pch_b, ifh_b, fl_b, hf_b, fz_b, je_b} !== e.ctl || ja_b !== e.ja ||
          berr_b !== e.berr || stall_b !== e.stall[3:0] || flush_b !== e.flush[3:0]) begin
        errors++;
        $display("FAIL %s (cnt4): got ctl=%b ja=%h berr=%b stall=%0d flush=%0d, need ctl=%b ja=%h berr=%b stall=%0d flush=%0d",
                 e.name, {pch_b, ifh_b, fl_b, hf_b, fz_b, je_b}, ja_b, berr_b, stall_b, flush_b,
                 e.ctl, e.ja, e.berr, e.stall[3:0], e.flush[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; busy = 1'b0; re = 1'b0; jen = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    u1 = 1'b0; u2 = 1'b0; ja = 32'd0;
    @(posedge clk);
    #1;
    cyc("rst_hold", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, CNone, 32'd0, 0);
    cyc("rst_jump", 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 32'h80, CNone, 32'd0, 0);
    idle("post_rst", 0);

    cyc("lu_rs1", 0, 0, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 32'd0, CLu, 32'd0, 0);
    idle("lu_clear", 0);
    cyc("lu_rd0", 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 32'd0, CNone, 32'd0, 0);
    cyc("lu_rs2", 0, 0, 1, 0, 5'd7, 5'd3, 5'd7, 1, 1, 32'd0, CLu, 32'd0, 0);
    cyc("rs2_unused", 0, 0, 1, 0, 5'd7, 5'd3, 5'd7, 1, 0, 32'd0, CNone, 32'd0, 0);
    cyc("no_load", 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 1, 1, 32'd0, CNone, 32'd0, 0);

    cyc("jump_over_lu", 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 32'h80, CJmp, 32'h80, 0);
    idle("after_jump", 0);

    cyc("frz_jump1", 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'h100, CFz, 32'd0, 0);
    cyc("frz_jump2", 0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 32'h100, CFz, 32'd0, 0);
    cyc("frz_jump3", 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'h100, CFz, 32'd0, 0);
    cyc("jump_after_frz", 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'h100, CJmp, 32'h100, 0);

    busy_n("busy15", 15);
    idle("busy15_done", 0);
    idle("busy15_ok", 0);

    busy_n("busy16", 16);
    cyc("err_frz_jump", 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'h44, CFz, 32'd0, 1);
    cyc("err_frz_lu", 0, 0, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 32'd0, CFz, 32'd0, 1);
    cyc("rst_in_err", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, CNone, 32'd0, 1);
    idle("err_cleared", 0);

    for (int i = 0; i < 17; i++)
      cyc("jump17", 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 32'(i * 4 + 4), CJmp, 32'(i * 4 + 4), 0);
    idle("flush_wrap", 0);

    busy_n("busy5", 5);
    cyc("rst_in_wait", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, CNone, 32'd0, 0);
    busy_n("busy15_b", 15);
    idle("wait_cleared", 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
